// File: rtl/tcam_pkg.sv
// Shared TCAM definitions: default geometry and reader state encoding,
// common to the TCAM array, the match reader and the search controller.
package tcam_pkg;

    localparam int unsigned ADDRESS_SIZE = 4;
    localparam int unsigned WORD_SIZE    = 1 << ADDRESS_SIZE;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit, plus flags
// for "any bit set" and "exactly one bit set".
module lowest_set_bit_encoder #(
    parameter  int unsigned width      = 16,
    localparam int unsigned index_size = (width > 1) ? $clog2(width) : 1
) (
    input  logic [width-1:0]      vector,
    output logic [index_size-1:0] index,
    output logic                  any,
    output logic                  single
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        index = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (vector[i]) begin
                index = index_size'(i);
            end
        end
    end

    assign any    = |vector;
    assign single = any && ((vector & (vector - width'(1))) == '0);

endmodule

// File: rtl/tcam_match_reader.sv
// Serialises a captured TCAM match vector into hit addresses, lowest index
// first, under a valid/ready handshake; also reports the hit count.
module tcam_match_reader
    import tcam_pkg::*;
#(
    parameter int unsigned address_size = ADDRESS_SIZE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [(1<<address_size)-1:0] match_vector,
    input  logic                        match_valid,
    output logic                        match_ready,
    output logic [address_size-1:0]     out_address,
    output logic                        out_none,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [address_size:0]       hit_count
);

    localparam int unsigned word_size  = 1 << address_size;
    localparam int unsigned count_size = address_size + 1;

    function automatic logic [count_size-1:0] popcount(input logic [word_size-1:0] v);
        logic [count_size-1:0] sum;
        sum = '0;
        for (int i = 0; i < word_size; i++) begin
            sum = sum + count_size'(v[i]);
        end
        return sum;
    endfunction

    state_t                  state;
    logic [word_size-1:0]    pending;
    logic [word_size-1:0]    pending_next;
    logic [address_size-1:0] next_index;
    logic                    next_any;
    logic                    next_single;

    // Value pending will hold after this edge; the next beat is encoded from it
    // so every out_* field comes straight from a flop.
    always_comb begin
        pending_next = pending;
        if (state == IDLE) begin
            pending_next = match_vector;
        end else if (out_ready) begin
            pending_next = pending & ~(word_size'(1) << out_address);
        end
    end

    lowest_set_bit_encoder #(
        .width (word_size)
    ) u_encoder (
        .vector (pending_next),
        .index  (next_index),
        .any    (next_any),
        .single (next_single)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            hit_count   <= '0;
            match_ready <= 1'b1;
            out_valid   <= 1'b0;
            out_none    <= 1'b0;
            out_last    <= 1'b0;
            out_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match_valid) begin
                        state       <= EMIT;
                        pending     <= pending_next;
                        hit_count   <= popcount(match_vector);
                        match_ready <= 1'b0;
                        out_valid   <= 1'b1;
                        out_none    <= !next_any;
                        out_last    <= !next_any || next_single;
                        out_address <= next_any ? next_index : '0;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state       <= IDLE;
                            pending     <= '0;
                            match_ready <= 1'b1;
                            out_valid   <= 1'b0;
                            out_none    <= 1'b0;
                            out_last    <= 1'b0;
                            out_address <= '0;
                        end else begin
                            pending     <= pending_next;
                            out_address <= next_index;
                            out_last    <= next_single;
                            out_none    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
